// File: rtl/hamming_uart_pkg.sv
// Shared definitions for the Hamming(7,4)-over-UART transmit and receive paths.
// Holds the frame state encoding, the line levels and the codeword bit layout.
package hamming_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   CODE_BITS = 7;

  // Codeword bit k holds Hamming position k+1; parity bits sit at positions 1, 2 and 4.
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P4_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

endpackage

// File: rtl/hamming_encoder_74.sv
// Combinational Hamming(7,4) encoder with optional single-bit error injection.
// inject_pos = n (1..7) inverts codeword bit n-1; 0 leaves the codeword clean.
module hamming_encoder_74
  import hamming_uart_pkg::*;
(
  input  logic [3:0]           data_in,
  input  logic [2:0]           inject_pos,
  output logic [CODE_BITS-1:0] code
);

  logic [CODE_BITS-1:0] clean;
  logic [CODE_BITS-1:0] flip;

  always_comb begin
    clean         = '0;
    clean[P1_POS] = data_in[0] ^ data_in[1] ^ data_in[3];
    clean[P2_POS] = data_in[0] ^ data_in[2] ^ data_in[3];
    clean[P4_POS] = data_in[1] ^ data_in[2] ^ data_in[3];
    clean[D0_POS] = data_in[0];
    clean[D1_POS] = data_in[1];
    clean[D2_POS] = data_in[2];
    clean[D3_POS] = data_in[3];

    flip = '0;
    if (inject_pos != 3'd0) begin
      flip[inject_pos - 3'd1] = 1'b1;
    end

    code = clean ^ flip;
  end

endmodule

// File: rtl/hamming_uart_tx.sv
// UART transmitter for Hamming(7,4) codewords: start bit, 7 code bits LSB first, stop bit.
// tx and busy are registered from the current state, so the line trails the FSM by one cycle.
module hamming_uart_tx
  import hamming_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [3:0]           data_in,
  input  logic [2:0]           inject_pos,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [2:0]           bit_idx,
  output logic [CODE_BITS-1:0] code_out
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(CODE_BITS - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [CODE_BITS-1:0] code_q, code_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic [CODE_BITS-1:0] enc_code;
  logic                 accept;
  logic                 bit_done;

  hamming_encoder_74 u_encoder (
    .data_in    (data_in),
    .inject_pos (inject_pos),
    .code       (enc_code)
  );

  // rst_n is folded in so nothing is offered while reset is held.
  assign in_ready = rst_n && ena && (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign bit_done = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    code_d    = code_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    if (ena) begin
      busy_d = (state_q != IDLE);
      tx_d   = STOP_BIT;
      cnt_d  = bit_done ? '0 : cnt_q + 1'b1;

      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (accept) begin
            code_d    = enc_code;
            bit_idx_d = 3'd0;
            state_d   = START;
          end
        end

        START: begin
          tx_d = START_BIT;
          if (bit_done) begin
            bit_idx_d = 3'd0;
            state_d   = DATA;
          end
        end

        DATA: begin
          tx_d = code_q[bit_idx_q];
          if (bit_done) begin
            if (bit_idx_q == IDX_LAST) begin
              bit_idx_d = 3'd0;
              state_d   = STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end

        STOP: begin
          tx_d = STOP_BIT;
          if (bit_done) begin
            state_d = IDLE;
          end
        end

        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      code_q    <= '0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      code_q    <= code_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign bit_idx  = bit_idx_q;
  assign code_out = code_q;

endmodule

// File: tb/tb_hamming_uart_tx.sv
// Self-checking bench for hamming_uart_tx: table vectors, hand-written corner sequences and
// random frames, all checked against a positional Hamming model and an ideal line waveform.
module tb_hamming_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 9 * CPB;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       ena        = 1'b1;
  logic [3:0] data_in    = 4'd0;
  logic [2:0] inject_pos = 3'd0;
  logic       in_valid   = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] bit_idx;
  logic [6:0] code_out;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] data;
    logic [2:0] inj;
    logic [6:0] code;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  hamming_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .data_in    (data_in),
    .inject_pos (inject_pos),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .bit_idx    (bit_idx),
    .code_out   (code_out)
  );

  // Codeword built from Hamming positions 1..7: data at 3,5,6,7, parity j covers positions with bit j set.
  function automatic logic [6:0] model_encode(input logic [3:0] d, input logic [2:0] inj);
    logic [7:0] w;
    int dpos[4];
    logic p;
    dpos = '{3, 5, 6, 7};
    w = '0;
    for (int i = 0; i < 4; i++) w[dpos[i]] = d[i];
    for (int j = 1; j < 8; j = j * 2) begin
      p = 1'b0;
      for (int q = 1; q < 8; q++) if (((q & j) != 0) && (q != j)) p = p ^ w[q];
      w[j] = p;
    end
    if (inj != 3'd0) w[inj] = ~w[inj];
    return w[7:1];
  endfunction

  function automatic void model_decode(input logic [6:0] c, output int syn, output logic [3:0] d);
    logic [7:0] w;
    w = {c, 1'b0};
    syn = 0;
    for (int q = 1; q < 8; q++) if (w[q]) syn = syn ^ q;
    if (syn != 0) w[syn] = ~w[syn];
    d = {w[7], w[6], w[5], w[3]};
  endfunction

  // Ideal line level k cycles after the accepting edge (k = 1..FRAME).
  function automatic logic exp_tx(input logic [6:0] c, input int k);
    if (k <= CPB) return 1'b0;
    if (k <= 8 * CPB) return c[(k - CPB - 1) / CPB];
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sends one nibble and follows the whole frame; pause_at/abort_at are frame cycle numbers or -1.
  task automatic apply_stimulus(input logic [3:0] d, input logic [2:0] inj, input logic [6:0] exp_code,
                                input bit keep_valid, input int pause_at, input int abort_at);
    int         waited;
    logic [6:0] rx;
    int         syn;
    logic [3:0] dec;
    data_in    = d;
    inject_pos = inj;
    in_valid   = 1'b1;
    waited     = 0;
    while (!in_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      check_output("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (keep_valid) check_output("b2b_wait", 32'(waited), 32'd0);
    tick();
    if (!keep_valid) in_valid = 1'b0;
    data_in    = ~d;
    inject_pos = 3'd5;
    check_output("code_out", 32'(code_out), 32'(exp_code));
    check_output("gap_tx", 32'(tx), 32'd1);
    check_output("gap_busy", 32'(busy), 32'd0);
    rx = '0;
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      check_output("tx_bit", 32'(tx), 32'(exp_tx(exp_code, k)));
      check_output("busy_hi", 32'(busy), 32'd1);
      if (k >= CPB && k < 8 * CPB)
        check_output("bit_idx", 32'(bit_idx), 32'((k - CPB) / CPB));
      if (k > CPB && k <= 8 * CPB && ((k - CPB - 1) % CPB) == CPB / 2)
        rx[(k - CPB - 1) / CPB] = tx;
      if (k == abort_at) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check_output("abort_tx", 32'(tx), 32'd1);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_ready", 32'(in_ready), 32'd0);
        check_output("abort_idx", 32'(bit_idx), 32'd0);
        check_output("abort_code", 32'(code_out), 32'd0);
        rst_n = 1'b1;
        #1;
        check_output("abort_ready_after", 32'(in_ready), 32'd1);
        return;
      end
      if (k == pause_at) begin
        ena = 1'b0;
        #1;
        check_output("pause_ready", 32'(in_ready), 32'd0);
        for (int j = 0; j < 10; j++) begin
          tick();
          check_output("pause_tx", 32'(tx), 32'(exp_tx(exp_code, k)));
          check_output("pause_idx", 32'(bit_idx), 32'((k - CPB) / CPB));
          check_output("pause_busy", 32'(busy), 32'd1);
        end
        ena = 1'b1;
      end
    end
    check_output("rx_code", 32'(rx), 32'(exp_code));
    model_decode(rx, syn, dec);
    check_output("rx_syndrome", 32'(syn), 32'(inj));
    check_output("rx_data", 32'(dec), 32'(d));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0] rd;
    logic [2:0] ri;
    bit         rk;

    vecs[0] = '{4'b1011, 3'd0, 7'b1010101};
    vecs[1] = '{4'b1011, 3'd3, 7'b1010001};
    vecs[2] = '{4'b0110, 3'd0, 7'b0110011};
    vecs[3] = '{4'b0001, 3'd7, 7'b1000111};
    vecs[4] = '{4'b1000, 3'd1, 7'b1001010};
    vecs[5] = '{4'b0101, 3'd0, 7'b0101101};

    rst_n = 1'b0;
    tick();
    check_output("rst_ready", 32'(in_ready), 32'd0);
    check_output("rst_tx", 32'(tx), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_output("post_rst_ready", 32'(in_ready), 32'd1);
    check_output("post_rst_tx", 32'(tx), 32'd1);
    check_output("post_rst_busy", 32'(busy), 32'd0);
    check_output("post_rst_code", 32'(code_out), 32'd0);
    check_output("post_rst_idx", 32'(bit_idx), 32'd0);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i].data, vecs[i].inj, vecs[i].code, 1'b0, -1, -1);
      tick();
    end

    apply_stimulus(4'b0000, 3'd0, 7'b0000000, 1'b1, -1, -1);
    apply_stimulus(4'b1111, 3'd0, 7'b1111111, 1'b0, -1, -1);
    tick();

    apply_stimulus(4'b1011, 3'd0, 7'b1010101, 1'b0, 14, -1);
    tick();

    apply_stimulus(4'b1011, 3'd0, 7'b1010101, 1'b0, -1, 22);
    apply_stimulus(4'b0110, 3'd0, 7'b0110011, 1'b0, -1, -1);
    tick();

    for (int i = 0; i < 10; i++) begin
      rd = 4'($urandom_range(0, 15));
      ri = 3'($urandom_range(0, 7));
      rk = (i < 9) && ($urandom_range(0, 1) == 1);
      apply_stimulus(rd, ri, model_encode(rd, ri), rk, -1, -1);
    end

    tick();
    check_output("final_tx", 32'(tx), 32'd1);
    check_output("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
